// File: rtl/car_motion_if.sv
// car_motion_if: frame/frog inputs and car position outputs of the car motion controller
interface car_motion_if;
  logic vsync;
  logic [3:0] current_level;
  logic level_load;
  logic pause;
  logic [9:0] frog_x;
  logic [9:0] frog_y;
  logic [109:0] car_x_flat;
  logic [109:0] car_y_flat;
  logic frame_tick;
  logic hit;
  logic frozen;
  modport master (
    output vsync, current_level, level_load, pause, frog_x, frog_y,
    input car_x_flat, car_y_flat, frame_tick, hit, frozen
  );
  modport slave (
    input vsync, current_level, level_load, pause, frog_x, frog_y,
    output car_x_flat, car_y_flat, frame_tick, hit, frozen
  );
endinterface

// File: rtl/car_motion_controller.sv
// car_motion_controller: moves 11 road cars once per frame, detects frog hits and freezes cars.
// Optional LEVEL_SPEEDUP_EN adds the clamped level to every car's step.
module car_motion_controller #(
  parameter int H_DISPLAY    = 640,
  parameter int CAR_SIZE     = 32,
  parameter int FROG_SIZE    = 32,
  parameter int LANE_Y0      = 64,
  parameter int LANE_PITCH   = 32,
  parameter int INIT_SPACING = 96,
  parameter int HIT_FRAMES   = 30
) (
  input logic clk,
  input logic rst_n,
  car_motion_if.slave bus
);
  localparam int N = 11;
  localparam int CW = $clog2(HIT_FRAMES);
  typedef enum logic {RUN, HIT} state_t;
  state_t state;
  logic vsync_d, tick, any_hit, hit_q, frozen_q;
  logic [CW-1:0] cnt;
  logic [9:0] x [N];
  logic [9:0] nx [N];
  logic [3:0] bump;
`ifdef LEVEL_SPEEDUP_EN
  assign bump = bus.current_level > 4'd7 ? 4'd7 : bus.current_level;
`else
  assign bump = 4'd0;
`endif
  function automatic logic [9:0] move(input logic [9:0] cur, input logic [3:0] st, input logic left);
    logic [10:0] s;
    s = {1'b0, cur} + {7'd0, st};
    return left ? (cur < {6'd0, st} ? 10'(11'(H_DISPLAY) + {1'b0, cur} - {7'd0, st}) : cur - {6'd0, st})
                : (s >= 11'(H_DISPLAY) ? 10'(s - 11'(H_DISPLAY)) : s[9:0]);
  endfunction
  assign tick = bus.vsync & ~vsync_d;
  assign bus.frame_tick = tick;
  assign bus.hit = hit_q;
  assign bus.frozen = frozen_q;
  // overlap uses plain 11-bit compares on pre-update positions; no wrap-around boxes
  always_comb begin
    any_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      nx[i] = move(x[i], 4'(1 + i % 3) + bump, 1'(i % 2));
      any_hit = any_hit |
        (({1'b0, bus.frog_x} < {1'b0, x[i]} + 11'(CAR_SIZE)) &&
         ({1'b0, x[i]} < {1'b0, bus.frog_x} + 11'(FROG_SIZE)) &&
         ({1'b0, bus.frog_y} < 11'(LANE_Y0 + i * LANE_PITCH + CAR_SIZE)) &&
         (11'(LANE_Y0 + i * LANE_PITCH) < {1'b0, bus.frog_y} + 11'(FROG_SIZE)));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      state <= RUN;
      hit_q <= 1'b0;
      frozen_q <= 1'b0;
      cnt <= '0;
      for (int i = 0; i < N; i++) x[i] <= 10'((i * INIT_SPACING) % H_DISPLAY);
    end else begin
      vsync_d <= bus.vsync;
      hit_q <= 1'b0;
      if (bus.level_load) begin
        state <= RUN;
        frozen_q <= 1'b0;
        cnt <= '0;
        for (int i = 0; i < N; i++) x[i] <= 10'((i * INIT_SPACING) % H_DISPLAY);
      end else if (tick && !bus.pause) begin
        if (state == RUN && any_hit) begin
          hit_q <= 1'b1;
          frozen_q <= 1'b1;
          state <= HIT;
          cnt <= CW'(HIT_FRAMES - 1);
        end else if (state == RUN) begin
          for (int i = 0; i < N; i++) x[i] <= nx[i];
        end else if (cnt == '0) begin
          state <= RUN;
          frozen_q <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
  for (genvar g = 0; g < N; g++) begin : g_flat
    assign bus.car_x_flat[10*g +: 10] = x[g];
    assign bus.car_y_flat[10*g +: 10] = 10'(LANE_Y0 + g * LANE_PITCH);
  end
endmodule

// File: tb/tb_car_motion_controller.sv
// tb_car_motion_controller: randomized and directed checks against a frame-level model of car motion.
module tb_car_motion_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  car_motion_if bus();
  car_motion_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errors = 0;
  int checks = 0;
  int mx [11];
  bit mfrozen, mhit;
  int mcnt;
  int reset_x [11] = '{0, 96, 192, 288, 384, 480, 576, 32, 128, 224, 320};
  function automatic int car_x(input int i);
    return int'(bus.car_x_flat[10*i +: 10]);
  endfunction
  function automatic int car_y(input int i);
    return int'(bus.car_y_flat[10*i +: 10]);
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < 11; i++) mx[i] = (i * 96) % 640;
    mfrozen = 0;
    mcnt = 0;
    mhit = 0;
  endfunction
  function automatic int model_step(input int i);
    int lvl;
    lvl = 0;
`ifdef LEVEL_SPEEDUP_EN
    lvl = (int'(bus.current_level) > 7) ? 7 : int'(bus.current_level);
`endif
    return 1 + i % 3 + lvl;
  endfunction
  function automatic bit model_overlap();
    int fx, fy, cy;
    bit any;
    fx = int'(bus.frog_x);
    fy = int'(bus.frog_y);
    any = 0;
    for (int i = 0; i < 11; i++) begin
      cy = 64 + 32 * i;
      if (fx < mx[i] + 32 && mx[i] < fx + 32 && fy < cy + 32 && cy < fy + 32) any = 1;
    end
    return any;
  endfunction
  function automatic void model_tick(input bit ld);
    mhit = 0;
    if (ld) model_reset();
    else if (!bus.pause) begin
      if (!mfrozen) begin
        if (model_overlap()) begin
          mhit = 1;
          mfrozen = 1;
          mcnt = 29;
        end else begin
          for (int i = 0; i < 11; i++)
            mx[i] = (i % 2 == 0) ? (mx[i] + model_step(i)) % 640 : (mx[i] - model_step(i) + 640) % 640;
        end
      end else if (mcnt == 0) mfrozen = 0;
      else mcnt--;
    end
  endfunction
  task automatic pulse(input bit ld);
    @(negedge clk);
    bus.vsync = 1'b1;
    bus.level_load = ld;
    model_tick(ld);
    @(negedge clk);
    bus.vsync = 1'b0;
    bus.level_load = 1'b0;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (car_x(i) !== reset_x[i]) begin errors++; $display("FAIL reset_x%0d got %0d want %0d", i, car_x(i), reset_x[i]); end
      checks++;
      if (car_y(i) !== 64 + 32 * i) begin errors++; $display("FAIL reset_y%0d got %0d want %0d", i, car_y(i), 64 + 32 * i); end
    end
    checks++;
    if ({bus.hit, bus.frozen, bus.frame_tick} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {bus.hit, bus.frozen, bus.frame_tick});
    end
  endtask
  task automatic test_first_tick();
    bus.current_level = 4'd0;
    bus.frog_x = 10'd0;
    bus.frog_y = 10'd448;
    @(negedge clk);
    bus.vsync = 1'b1;
    #1;
    checks++;
    if (bus.frame_tick !== 1'b1) begin errors++; $display("FAIL frame_tick_rise got %b want 1", bus.frame_tick); end
    model_tick(0);
    @(negedge clk);
    checks++;
    if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL frame_tick_hold got %b want 0", bus.frame_tick); end
    bus.vsync = 1'b0;
    checks++;
    if (car_x(0) !== 1 || car_x(1) !== 94 || car_x(2) !== 195) begin
      errors++; $display("FAIL first_tick got %0d,%0d,%0d want 1,94,195", car_x(0), car_x(1), car_x(2));
    end
    checks++;
    if (car_y(10) !== 384 || bus.hit !== 1'b0) begin
      errors++; $display("FAIL first_tick_y10_hit got %0d,%b want 384,0", car_y(10), bus.hit);
    end
  endtask
  task automatic test_wrap();
    int e6, e7;
    pulse(1);
    bus.current_level = 4'd3;
    repeat (16) pulse(0);
`ifdef LEVEL_SPEEDUP_EN
    e6 = 0; e7 = 592;
`else
    e6 = 592; e7 = 0;
`endif
    checks++;
    if (car_x(6) !== e6 || car_x(7) !== e7) begin
      errors++; $display("FAIL level3_wrap got %0d,%0d want %0d,%0d", car_x(6), car_x(7), e6, e7);
    end
    pulse(1);
    bus.current_level = 4'd0;
    repeat (16) pulse(0);
    checks++;
    if (car_x(7) !== 0) begin errors++; $display("FAIL wrap_x7_t16 got %0d want 0", car_x(7)); end
    pulse(0);
    checks++;
    if (car_x(7) !== 638) begin errors++; $display("FAIL wrap_x7_t17 got %0d want 638", car_x(7)); end
  endtask
  task automatic test_level_clamp();
    int e0;
    pulse(1);
    bus.current_level = 4'd12;
    pulse(0);
`ifdef LEVEL_SPEEDUP_EN
    e0 = 8;
`else
    e0 = 1;
`endif
    checks++;
    if (car_x(0) !== e0) begin errors++; $display("FAIL level_clamp got %0d want %0d", car_x(0), e0); end
    bus.current_level = 4'd0;
  endtask
  task automatic test_hit();
    pulse(1);
    bus.frog_x = 10'd0;
    bus.frog_y = 10'd64;
    pulse(0);
    checks++;
    if ({bus.hit, bus.frozen} !== 2'b11 || car_x(0) !== 0) begin
      errors++; $display("FAIL hit_start got hit=%b frozen=%b x0=%0d want 1 1 0", bus.hit, bus.frozen, car_x(0));
    end
    @(negedge clk);
    checks++;
    if (bus.hit !== 1'b0) begin errors++; $display("FAIL hit_width got %b want 0", bus.hit); end
    bus.frog_y = 10'd448;
    for (int k = 1; k <= 30; k++) begin
      pulse(0);
      checks++;
      if (car_x(0) !== 0 || car_x(1) !== 96 || bus.frozen !== (k < 30) || bus.hit !== 1'b0) begin
        errors++; $display("FAIL hit_hold tick %0d got x0=%0d x1=%0d frozen=%b hit=%b", k, car_x(0), car_x(1), bus.frozen, bus.hit);
      end
    end
    pulse(0);
    checks++;
    if (car_x(0) !== 1) begin errors++; $display("FAIL hit_resume got %0d want 1", car_x(0)); end
  endtask
  task automatic test_pause();
    pulse(1);
    bus.frog_x = 10'd0;
    bus.frog_y = 10'd64;
    bus.pause = 1'b1;
    repeat (5) pulse(0);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (car_x(i) !== reset_x[i]) begin errors++; $display("FAIL pause_x%0d got %0d want %0d", i, car_x(i), reset_x[i]); end
    end
    checks++;
    if ({bus.hit, bus.frozen} !== 2'b00) begin errors++; $display("FAIL pause_flags got %b want 00", {bus.hit, bus.frozen}); end
    bus.pause = 1'b0;
    bus.frog_y = 10'd448;
  endtask
  task automatic test_load_tick();
    pulse(1);
    repeat (3) pulse(0);
    bus.frog_x = 10'd0;
    bus.frog_y = 10'd64;
    pulse(0);
    checks++;
    if (bus.frozen !== 1'b1) begin errors++; $display("FAIL load_setup frozen got %b want 1", bus.frozen); end
    pulse(1);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (car_x(i) !== reset_x[i]) begin errors++; $display("FAIL load_x%0d got %0d want %0d", i, car_x(i), reset_x[i]); end
    end
    checks++;
    if ({bus.hit, bus.frozen} !== 2'b00) begin errors++; $display("FAIL load_flags got %b want 00", {bus.hit, bus.frozen}); end
    bus.frog_y = 10'd448;
    pulse(0);
    checks++;
    if (car_x(0) !== 1) begin errors++; $display("FAIL load_run got %0d want 1", car_x(0)); end
  endtask
  task automatic test_random();
    pulse(1);
    for (int n = 0; n < 250; n++) begin
      bus.current_level = 4'($urandom_range(0, 15));
      bus.frog_x = 10'($urandom_range(0, 1023));
      bus.frog_y = 10'($urandom_range(0, 500));
      bus.pause = ($urandom_range(0, 7) == 0);
      pulse($urandom_range(0, 19) == 0);
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (car_x(i) !== mx[i]) begin errors++; $display("FAIL rand_x%0d frame %0d got %0d want %0d", i, n, car_x(i), mx[i]); end
      end
      checks++;
      if (bus.hit !== mhit || bus.frozen !== mfrozen) begin
        errors++; $display("FAIL rand_flags frame %0d got hit=%b frozen=%b want %b %b", n, bus.hit, bus.frozen, mhit, mfrozen);
      end
      bus.current_level = 4'($urandom_range(0, 15));
      @(negedge clk);
      checks++;
      if (bus.hit !== 1'b0) begin errors++; $display("FAIL rand_hit_width frame %0d got %b want 0", n, bus.hit); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    bus.pause = 1'b0;
  endtask
  initial begin
    bus.vsync = 1'b0;
    bus.current_level = 4'd0;
    bus.level_load = 1'b0;
    bus.pause = 1'b0;
    bus.frog_x = 10'd0;
    bus.frog_y = 10'd448;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_first_tick();
    test_wrap();
    test_level_clamp();
    test_hit();
    test_pause();
    test_load_tick();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
